// File: rtl/playseq_pkg.sv
// Shared definitions for the PlaySeq button conditioning stage: FSM state
// encoding and a one-hot test used on the filtered button vector.
package playseq_pkg;

    typedef enum logic [1:0] {
        OCIOSO        = 2'b00,
        PRESSIONADO   = 2'b01,
        INVALIDO      = 2'b10,
        ESPERA_SOLTAR = 2'b11
    } estado_t;

    // True when exactly one bit of v is set (v & (v-1) clears the lowest set bit).
    function automatic logic eh_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/playseq_debounce_bit.sv
// One button bit: 2-FF synchroniser followed by a debounce counter that only
// lets the filtered level follow after DEBOUNCE_CYCLES consecutive stable cycles.
module playseq_debounce_bit
    import playseq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic bruto,
    output logic filtrado
);

    logic          sinc1_q;
    logic          sinc_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1_q <= 1'b0;
            sinc_q  <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sinc1_q <= bruto;
            sinc_q  <= sinc1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter value DEBOUNCE_CYCLES-1 plus the current differing cycle
    // makes DEBOUNCE_CYCLES stable cycles, so the level is taken on that edge.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sinc_q != filt_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sinc_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign filtrado = filt_q;

endmodule

// File: rtl/playseq_condiciona_botoes.sv
// Conditions raw push buttons for the PlaySeq datapath: per-bit debounce, then an
// FSM that emits a held one-hot vector, an accept pulse and a multi-press reject pulse.
// Optional rejected-press counter enabled by defining PLAYSEQ_CONTA_REJEICOES_EN.
module playseq_condiciona_botoes
    import playseq_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] botoes_brutos,
    input  logic         habilita,
    output logic [N-1:0] botoes,
    output logic         jogada_pulso,
    output logic         jogada_invalida,
    output logic [1:0]   db_estado,
    output logic [3:0]   db_rejeicoes
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [N-1:0] filtrado;

    for (genvar i = 0; i < N; i++) begin : g_db
        playseq_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CW              (CW)
        ) u_db (
            .clock    (clock),
            .reset    (reset),
            .bruto    (botoes_brutos[i]),
            .filtrado (filtrado[i])
        );
    end

    estado_t      estado_q, estado_d;
    logic [N-1:0] trava_q, trava_d;
    logic [N-1:0] botoes_q, botoes_d;
    logic         pulso_q, pulso_d;
    logic         inval_q, inval_d;
    logic         one_hot;

    assign one_hot = eh_one_hot(32'(filtrado));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            trava_q  <= '0;
            botoes_q <= '0;
            pulso_q  <= 1'b0;
            inval_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            trava_q  <= trava_d;
            botoes_q <= botoes_d;
            pulso_q  <= pulso_d;
            inval_q  <= inval_d;
        end
    end

    // Outputs are computed together with the next state so they are registered
    // and line up with db_estado.
    always_comb begin
        estado_d = estado_q;
        trava_d  = trava_q;
        botoes_d = '0;
        pulso_d  = 1'b0;
        inval_d  = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (filtrado != '0) begin
                    if (!habilita) begin
                        estado_d = ESPERA_SOLTAR;
                    end else if (one_hot) begin
                        estado_d = PRESSIONADO;
                        trava_d  = filtrado;
                        botoes_d = filtrado;
                        pulso_d  = 1'b1;
                    end else begin
                        estado_d = INVALIDO;
                        inval_d  = 1'b1;
                    end
                end
            end
            PRESSIONADO: begin
                botoes_d = trava_q;
                if (filtrado == '0) begin
                    estado_d = OCIOSO;
                    botoes_d = '0;
                end else if (filtrado != trava_q) begin
                    estado_d = ESPERA_SOLTAR;
                    botoes_d = '0;
                end
            end
            INVALIDO, ESPERA_SOLTAR: begin
                if (filtrado == '0) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign botoes          = botoes_q;
    assign jogada_pulso    = pulso_q;
    assign jogada_invalida = inval_q;
    assign db_estado       = estado_q;

`ifdef PLAYSEQ_CONTA_REJEICOES_EN
    logic       rejeita;
    logic [3:0] rej_q;

    // A rejection is either a multi-press seen from idle or a second button
    // added on top of an accepted one.
    assign rejeita = inval_d || ((estado_q == PRESSIONADO) && (estado_d == ESPERA_SOLTAR));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rej_q <= 4'd0;
        end else if (rejeita && (rej_q != 4'hF)) begin
            rej_q <= rej_q + 4'd1;
        end
    end

    assign db_rejeicoes = rej_q;
`else
    assign db_rejeicoes = 4'b0000;
`endif

endmodule

// File: doc/playseq_condiciona_botoes.md
Name: playseq_condiciona_botoes

Overview:
Input conditioning stage directly upstream of the PlaySeq datapath. It takes the raw, asynchronous push-button vector and delivers what the datapath's `botoes` input needs:
- a synchronised, debounced, one-hot-or-zero vector;
- a one-cycle pulse per accepted press;
- a flag for rejected multi-button presses.

Its outputs feed the datapath's button register, RAM write data and LED/buzzer path unchanged.

Parameters:
- N, 4, number of buttons (width of all button vectors).
- DEBOUNCE_CYCLES, 20, consecutive stable cycles needed to accept a level change (20 ms at the 1 kHz game clock).
- CW, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; not to be overridden).

Ports:
- clock, in, 1, game clock.
- reset, in, 1, asynchronous active-high reset.
- botoes_brutos, in, N, raw button levels, asynchronous to clock.
- habilita, in, 1, FSM permits new presses to be accepted.
- botoes, out, N, conditioned vector, one-hot or zero.
- jogada_pulso, out, 1, one-cycle pulse when a valid press is accepted.
- jogada_invalida, out, 1, one-cycle pulse when a multi-button press is rejected.
- db_estado, out, 2, current FSM state.
- db_rejeicoes, out, 4, rejected-press count (see Optional Feature).

Behaviour:

Reset
- Asynchronous and active-high.
- All flops clear: synchroniser, filtered vector, counters, latch.
- botoes=0, jogada_pulso=0, jogada_invalida=0, db_estado=OCIOSO (2'b00), db_rejeicoes=0.
- Reset asserted mid-press: everything clears immediately. After release a still-held button is re-debounced from zero.

Synchroniser
- 2-FF synchroniser per bit produces `sinc`.

Debounce (per bit)
- Counter runs while sinc[i] != filtrado[i]. It clears whenever they are equal.
- When the count reaches DEBOUNCE_CYCLES, filtrado[i] takes sinc[i] and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES never changes filtrado.

FSM (registered outputs)
- OCIOSO (00)
  - filtrado one-hot and habilita=1: latch filtrado, go to PRESSIONADO, pulse jogada_pulso.
  - filtrado has ≥2 bits set and habilita=1: go to INVALIDO, pulse jogada_invalida.
  - filtrado nonzero and habilita=0: go to ESPERA_SOLTAR, no pulse.
- PRESSIONADO (01)
  - botoes = latch.
  - filtrado==0: go to OCIOSO, botoes=0.
  - filtrado != latch and nonzero (a second button was added): go to ESPERA_SOLTAR, botoes=0, no further pulse.
  - habilita has no effect here. A press already accepted is held until release.
- INVALIDO (10) and ESPERA_SOLTAR (11)
  - botoes=0.
  - filtrado==0: go to OCIOSO.

Output timing
- botoes is nonzero only in PRESSIONADO.
- jogada_pulso is high for exactly one cycle per press. Holding a button never re-pulses.
- jogada_pulso and jogada_invalida are never high in the same cycle.

Latency
- Raw edge stable from cycle 0 → filtrado changes at cycle 2+DEBOUNCE_CYCLES.
- botoes and jogada_pulso assert at cycle 3+DEBOUNCE_CYCLES.
- Release latency is identical.

Simultaneous events
- Two bits that become stable in the same cycle count as a multi-press (INVALIDO).
- habilita rising while a button is already held does not accept that button. It must be released first.

Optional Feature:
- Macro: PLAYSEQ_CONTA_REJEICOES_EN.
- Defined: db_rejeicoes is a 4-bit saturating counter (stops at 15). It increments on each jogada_invalida pulse and on each PRESSIONADO→ESPERA_SOLTAR transition. It clears only on reset.
- Undefined: the counter logic is absent and db_rejeicoes is tied to 4'b0000. The port list is identical in both builds.

Decomposition:
- Package playseq_pkg holds:
  - the state encoding constants OCIOSO, PRESSIONADO, INVALIDO, ESPERA_SOLTAR (2-bit);
  - a one-hot check function returning true when exactly one bit is set.
- One sub-module, playseq_debounce_bit: 2-FF synchroniser, debounce counter and filtered flop for a single bit. It is instantiated N times via generate.
- The FSM, latch and optional counter stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, habilita=1 unless stated.
1. botoes_brutos=0010 held from cycle 0 → botoes=0010 and jogada_pulso=1 at cycle 7 only. Held for 50 cycles → no second pulse. Release → botoes=0000 at cycle release+7.
2. botoes_brutos=0001 for 3 cycles, then 0000 (bounce) → filtrado unchanged, botoes stays 0000, no pulse.
3. botoes_brutos=0101 stable → jogada_invalida single pulse at cycle 7, botoes=0000, db_estado=10. Release → OCIOSO. With the macro defined, db_rejeicoes=1.
4. Hold 1000 until accepted, then add 0001 (raw=1001) → botoes drops to 0000 once debounced, db_estado=11, no pulse. Release all → 00.
5. habilita=0, press 0100, raise habilita while held → no pulse, state 11. Release, press 0100 again → normal acceptance with pulse.
6. Assert reset in PRESSIONADO with button held → all outputs 0 asynchronously. Deassert with button still held → botoes=0100 and pulse 7 cycles after reset release.
